poly_ram_arbiter: RTL

Parametrised two-port arbiter between N polynomial-engine clients and the dual-port coefficient RAM. Each cycle it grants up to two client requests, one on each RAM port, and prevents write/write collisions on the same address. It tracks every read in flight so the RAM data returns to the client that issued it, `RD_LAT` cycles later. It replaces the hard-wired port mux at the Kyber top level, so more engines (CBD, A generator, NTT, coder, hash) can share the RAM without hand-written priority chains.

---
 rtl/poly_ram_arbiter_if.sv | 45 ++++
 rtl/poly_ram_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/poly_ram_arbiter_if.sv
// Bus bundle between polynomial-engine clients, the RAM arbiter and the
// dual-port coefficient RAM. The arbiter sits on the slave modport.
interface poly_ram_arbiter_if #(
   parameter int N_CLIENTS = 4,
   parameter int ADDR_W    = 9,
   parameter int DATA_W    = 96
);
   logic [N_CLIENTS-1:0]        req;
   logic [N_CLIENTS-1:0]        wen;
   logic [N_CLIENTS*ADDR_W-1:0] addr;
   logic [N_CLIENTS*DATA_W-1:0] wdata;
   logic [N_CLIENTS-1:0]        gnt;
   logic [N_CLIENTS-1:0]        rvalid;
   logic [N_CLIENTS*DATA_W-1:0] rdata;

   logic              ram_en_a;
   logic              ram_wen_a;
   logic [ADDR_W-1:0] ram_addr_a;
   logic [DATA_W-1:0] ram_wdata_a;
   logic [DATA_W-1:0] ram_rdata_a;
   logic              ram_en_b;
   logic              ram_wen_b;
   logic [ADDR_W-1:0] ram_addr_b;
   logic [DATA_W-1:0] ram_wdata_b;
   logic [DATA_W-1:0] ram_rdata_b;

   logic              stall_clr;
   logic [15:0]       stall_cnt;

   modport master (
      output req, wen, addr, wdata, ram_rdata_a, ram_rdata_b, stall_clr,
      input  gnt, rvalid, rdata,
      input  ram_en_a, ram_wen_a, ram_addr_a, ram_wdata_a,
      input  ram_en_b, ram_wen_b, ram_addr_b, ram_wdata_b,
      input  stall_cnt
   );

   modport slave (
      input  req, wen, addr, wdata, ram_rdata_a, ram_rdata_b, stall_clr,
      output gnt, rvalid, rdata,
      output ram_en_a, ram_wen_a, ram_addr_a, ram_wdata_a,
      output ram_en_b, ram_wen_b, ram_addr_b, ram_wdata_b,
      output stall_cnt
   );
endinterface

// File: rtl/poly_ram_arbiter.sv
// Two-port arbiter between N polynomial-engine clients and the dual-port
// coefficient RAM, with read-return routing and a stall counter.
module poly_ram_arbiter #(
   parameter int N_CLIENTS = 4,
   parameter int ADDR_W    = 9,
   parameter int DATA_W    = 96,
   parameter int RD_LAT    = 1,
   parameter int RR_EN     = 0
) (
   input logic              clk,
   input logic              rst,
   poly_ram_arbiter_if.slave bus
);
   localparam int IDX_W = $clog2(N_CLIENTS);

   logic [IDX_W-1:0]     r_ptr;
   logic [IDX_W-1:0]     w_ptr;
   logic                 w_a_vld;
   logic                 w_b_vld;
   logic [IDX_W-1:0]     w_a_idx;
   logic [IDX_W-1:0]     w_b_idx;
   logic [IDX_W-1:0]     w_idx;
   logic [IDX_W:0]       w_sum;
   logic [N_CLIENTS-1:0] w_gnt;
   logic                 w_rd_a;
   logic                 w_rd_b;
   logic [15:0]          r_stall_cnt;

   logic                 r_tag_a_vld [RD_LAT];
   logic                 r_tag_b_vld [RD_LAT];
   logic [IDX_W-1:0]     r_tag_a_idx [RD_LAT];
   logic [IDX_W-1:0]     r_tag_b_idx [RD_LAT];
   logic [N_CLIENTS-1:0] w_hit_a;
   logic [N_CLIENTS-1:0] w_hit_b;

   assign w_ptr = (RR_EN != 0) ? r_ptr : '0;

   // Walk clients in priority order from w_ptr; first requester takes port A,
   // next one that does not write the same address as A takes port B.
   always_comb begin
      w_a_vld = 1'b0;
      w_b_vld = 1'b0;
      w_a_idx = '0;
      w_b_idx = '0;
      w_sum   = '0;
      w_idx   = '0;
      for (int k = 0; k < N_CLIENTS; k++) begin
         w_sum = {1'b0, w_ptr} + (IDX_W+1)'(k);
         if (w_sum >= (IDX_W+1)'(N_CLIENTS))
            w_sum = w_sum - (IDX_W+1)'(N_CLIENTS);
         w_idx = w_sum[IDX_W-1:0];
         if (bus.req[w_idx]) begin
            if (!w_a_vld) begin
               w_a_vld = 1'b1;
               w_a_idx = w_idx;
            end else if (!w_b_vld &&
                         !(bus.wen[w_idx] && bus.wen[w_a_idx] &&
                           (bus.addr[w_idx*ADDR_W +: ADDR_W] ==
                            bus.addr[w_a_idx*ADDR_W +: ADDR_W]))) begin
               w_b_vld = 1'b1;
               w_b_idx = w_idx;
            end
         end
      end
   end

   always_comb begin
      w_gnt = '0;
      if (w_a_vld) w_gnt[w_a_idx] = 1'b1;
      if (w_b_vld) w_gnt[w_b_idx] = 1'b1;
   end

   assign bus.gnt         = w_gnt;
   assign bus.ram_en_a    = w_a_vld;
   assign bus.ram_wen_a   = w_a_vld & bus.wen[w_a_idx];
   assign bus.ram_addr_a  = w_a_vld ? bus.addr[w_a_idx*ADDR_W +: ADDR_W]  : '0;
   assign bus.ram_wdata_a = w_a_vld ? bus.wdata[w_a_idx*DATA_W +: DATA_W] : '0;
   assign bus.ram_en_b    = w_b_vld;
   assign bus.ram_wen_b   = w_b_vld & bus.wen[w_b_idx];
   assign bus.ram_addr_b  = w_b_vld ? bus.addr[w_b_idx*ADDR_W +: ADDR_W]  : '0;
   assign bus.ram_wdata_b = w_b_vld ? bus.wdata[w_b_idx*DATA_W +: DATA_W] : '0;

   assign w_rd_a = w_a_vld & ~bus.wen[w_a_idx];
   assign w_rd_b = w_b_vld & ~bus.wen[w_b_idx];

   // One tag lane per RAM port, so the port is implied by the lane.
   generate
      for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_tag
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_tag_a_vld[gi] <= 1'b0;
               r_tag_b_vld[gi] <= 1'b0;
               r_tag_a_idx[gi] <= '0;
               r_tag_b_idx[gi] <= '0;
            end else if (gi == 0) begin
               r_tag_a_vld[gi] <= w_rd_a;
               r_tag_b_vld[gi] <= w_rd_b;
               r_tag_a_idx[gi] <= w_a_idx;
               r_tag_b_idx[gi] <= w_b_idx;
            end else begin
               r_tag_a_vld[gi] <= r_tag_a_vld[(gi > 0) ? gi-1 : 0];
               r_tag_b_vld[gi] <= r_tag_b_vld[(gi > 0) ? gi-1 : 0];
               r_tag_a_idx[gi] <= r_tag_a_idx[(gi > 0) ? gi-1 : 0];
               r_tag_b_idx[gi] <= r_tag_b_idx[(gi > 0) ? gi-1 : 0];
            end
         end
      end

      for (genvar gi = 0; gi < N_CLIENTS; gi++) begin : g_ret
         assign w_hit_a[gi] = r_tag_a_vld[RD_LAT-1] &&
                              (r_tag_a_idx[RD_LAT-1] == IDX_W'(gi));
         assign w_hit_b[gi] = r_tag_b_vld[RD_LAT-1] &&
                              (r_tag_b_idx[RD_LAT-1] == IDX_W'(gi));
         assign bus.rdata[gi*DATA_W +: DATA_W] =
            w_hit_a[gi] ? bus.ram_rdata_a :
            w_hit_b[gi] ? bus.ram_rdata_b : '0;
      end
   endgenerate

   assign bus.rvalid = w_hit_a | w_hit_b;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_ptr <= '0;
      else if ((RR_EN != 0) && w_a_vld)
         r_ptr <= (w_a_idx == IDX_W'(N_CLIENTS-1)) ? '0 : w_a_idx + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_stall_cnt <= '0;
      else if (bus.stall_clr)
         r_stall_cnt <= '0;
      else if (|(bus.req & ~w_gnt) && (r_stall_cnt != 16'hFFFF))
         r_stall_cnt <= r_stall_cnt + 16'd1;
   end

   assign bus.stall_cnt = r_stall_cnt;
endmodule
